// File: rtl/k16_panel_scan.sv
// rtl/k16_panel_scan.sv - K16 front-panel scan link endpoint: LED nibble capture, debounced switch serve, link timeout
// Optional build macro: K16_PANEL_SHADOW_EN (tear-free LED update through a 32-bit shadow frame)
module k16_panel_scan #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 250000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_clk,
    input  logic [2:0]  io_addr,
    input  logic [3:0]  io_leds,
    output logic [3:0]  io_switches,
    output logic [2:0]  io_reg_switches,
    input  logic [15:0] sw_addr,
    input  logic [15:0] sw_ctrl,
    input  logic [2:0]  sw_reg,
    output logic [15:0] led_addr,
    output logic [15:0] led_data,
    output logic        link_ok
);
    localparam int DW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   clk_dly_q;
    logic [2:0]             addr_sync_q [SYNC_STAGES];
    logic [3:0]             leds_sync_q [SYNC_STAGES];
    logic                   clk_s, rise, fall;
    logic [2:0]             addr_s, slot;
    logic [3:0]             leds_s;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign addr_s = addr_sync_q[SYNC_STAGES-1];
    assign leds_s = leds_sync_q[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_dly_q;
    assign fall   = ~clk_s & clk_dly_q;
    // The host has already advanced io_addr past the nibble it is presenting.
    assign slot   = addr_s - 3'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q <= '0;
            clk_dly_q  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_sync_q[i] <= '0;
                leds_sync_q[i] <= '0;
            end
        end else begin
            clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], io_clk};
            clk_dly_q      <= clk_s;
            addr_sync_q[0] <= io_addr;
            leds_sync_q[0] <= io_leds;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                addr_sync_q[i] <= addr_sync_q[i-1];
                leds_sync_q[i] <= leds_sync_q[i-1];
            end
        end
    end

    logic [DW-1:0] tick_cnt_q, tick_cnt_d;
    logic [34:0]   prev_q, prev_d, deb_q, deb_d, raw;
    logic          tick;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timed_out, link_q, link_d;
    logic [31:0]   led_q, led_d;
    logic [3:0]    sw_nib_q;
    logic [2:0]    reg_sw_q;
`ifdef K16_PANEL_SHADOW_EN
    logic [31:0]   shadow_q, shadow_d;
`endif

    assign raw       = {sw_reg, sw_ctrl, sw_addr};
    assign tick      = (tick_cnt_q == DW'(DEBOUNCE_TICKS - 1));
    assign timed_out = (to_cnt_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + DW'(1);
        prev_d     = prev_q;
        deb_d      = deb_q;
        if (tick) begin
            prev_d = raw;
            // Only bits that matched the previous sample are allowed through.
            deb_d  = (raw & ~(raw ^ prev_q)) | (deb_q & (raw ^ prev_q));
        end

        to_cnt_d = rise ? '0 : (timed_out ? to_cnt_q : to_cnt_q + TW'(1));
        link_d   = rise ? 1'b1 : (timed_out ? 1'b0 : link_q);

        led_d = led_q;
`ifdef K16_PANEL_SHADOW_EN
        shadow_d = shadow_q;
        if (timed_out) begin
            shadow_d = '0;
            led_d    = '0;
        end else if (fall) begin
            shadow_d[{slot, 2'b00} +: 4] = leds_s;
            if (slot == 3'd7) led_d = shadow_d;
        end
`else
        if (timed_out) led_d = '0;
        else if (fall) led_d[{slot, 2'b00} +: 4] = leds_s;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            prev_q     <= '0;
            deb_q      <= '0;
            to_cnt_q   <= '0;
            link_q     <= 1'b0;
            led_q      <= '0;
            sw_nib_q   <= '0;
            reg_sw_q   <= '0;
`ifdef K16_PANEL_SHADOW_EN
            shadow_q   <= '0;
`endif
        end else begin
            tick_cnt_q <= tick_cnt_d;
            prev_q     <= prev_d;
            deb_q      <= deb_d;
            to_cnt_q   <= to_cnt_d;
            link_q     <= link_d;
            led_q      <= led_d;
            // Served from the pre-tick debounced value.
            sw_nib_q   <= deb_q[{addr_s, 2'b00} +: 4];
            reg_sw_q   <= deb_q[34:32];
`ifdef K16_PANEL_SHADOW_EN
            shadow_q   <= shadow_d;
`endif
        end
    end

    assign io_switches     = sw_nib_q;
    assign io_reg_switches = reg_sw_q;
    assign led_addr        = led_q[15:0];
    assign led_data        = led_q[31:16];
    assign link_ok         = link_q;
endmodule

// File: tb/tb_k16_panel_scan.sv
// tb/tb_k16_panel_scan.sv - directed-vector bench for k16_panel_scan with a host scan model
module tb_k16_panel_scan;
    localparam int SS  = 2;
    localparam int DT  = 12;
    localparam int TOC = 400;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_clk;
    logic [2:0]  io_addr;
    logic [3:0]  io_leds;
    logic [3:0]  io_switches;
    logic [2:0]  io_reg_switches;
    logic [15:0] sw_addr, sw_ctrl;
    logic [2:0]  sw_reg;
    logic [15:0] led_addr, led_data;
    logic        link_ok;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] host_addr_w, host_data_w;
    logic [3:0]  host_sw [8];
    int          bounced, waited;
    logic        found;

    k16_panel_scan #(.SYNC_STAGES(SS), .DEBOUNCE_TICKS(DT), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .reset_n(reset_n), .io_clk(io_clk), .io_addr(io_addr), .io_leds(io_leds),
        .io_switches(io_switches), .io_reg_switches(io_reg_switches),
        .sw_addr(sw_addr), .sw_ctrl(sw_ctrl), .sw_reg(sw_reg),
        .led_addr(led_addr), .led_data(led_data), .link_ok(link_ok)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One host scan step for index a: sample io_switches, then rise with addr a+1 and nibble a.
    task automatic host_step(input int a);
        @(negedge clk);
        host_sw[a] = io_switches;
        io_clk     = 1'b1;
        io_addr    = 3'(a + 1);
        io_leds    = (a < 4) ? host_addr_w[a*4 +: 4] : host_data_w[(a-4)*4 +: 4];
        repeat (8) @(negedge clk);
        io_clk = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic host_frame();
        for (int a = 0; a < 8; a++) host_step(a);
    endtask

`ifdef K16_PANEL_SHADOW_EN
    logic mon_en = 1'b0;
    int   torn   = 0;
    always @(negedge clk)
        if (mon_en && led_data != 16'h0000 && led_data != 16'hFFFF) torn++;
`endif

    initial begin
        reset_n = 1'b0; io_clk = 1'b0; io_addr = '0; io_leds = '0;
        sw_addr = 16'hA5C3; sw_ctrl = 16'h0002; sw_reg = 3'b101;
        host_addr_w = 16'h1234; host_data_w = 16'hBEEF;

        repeat (5) @(negedge clk) io_clk = ~io_clk;
        check_vec("rst_io_switches", {28'd0, io_switches}, 32'd0);
        check_vec("rst_reg_switches", {29'd0, io_reg_switches}, 32'd0);
        check_vec("rst_led_addr", {16'd0, led_addr}, 32'd0);
        check_vec("rst_led_data", {16'd0, led_data}, 32'd0);
        check_vec("rst_link_ok", {31'd0, link_ok}, 32'd0);
        io_clk = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("link_before_rise", {31'd0, link_ok}, 32'd0);

        io_clk = 1'b1;
        repeat (SS) @(negedge clk);
        check_vec("link_at_ss", {31'd0, link_ok}, 32'd0);
        @(negedge clk);
        check_vec("link_at_ss_plus1", {31'd0, link_ok}, 32'd1);
        repeat (5) @(negedge clk);
        io_clk = 1'b0;
        repeat (30) @(negedge clk);

        for (int a = 0; a < 7; a++) host_step(a);
`ifdef K16_PANEL_SHADOW_EN
        check_vec("pre_slot7_addr", {16'd0, led_addr}, 32'h0000);
        check_vec("pre_slot7_data", {16'd0, led_data}, 32'h0000);
`else
        check_vec("pre_slot7_addr", {16'd0, led_addr}, 32'h1234);
        check_vec("pre_slot7_data", {16'd0, led_data}, 32'h0EEF);
`endif
        host_step(7);
        check_vec("slot7_wrap_data", {16'd0, led_data}, 32'hBEEF);

        host_frame();
        check_vec("frame2_led_addr", {16'd0, led_addr}, 32'h1234);
        check_vec("frame2_led_data", {16'd0, led_data}, 32'hBEEF);
        check_vec("host_addr_sw", {16'd0, host_sw[3], host_sw[2], host_sw[1], host_sw[0]}, 32'hA5C3);
        check_vec("host_ctrl_sw", {16'd0, host_sw[7], host_sw[6], host_sw[5], host_sw[4]}, 32'h0002);
        check_vec("reg_switches", {29'd0, io_reg_switches}, 32'd5);

        for (int a = 0; a < 4; a++) host_step(a);
        repeat (4) @(negedge clk);
        check_vec("serve_ctrl_nib0", {28'd0, io_switches}, 32'h2);
        bounced = 0;
        for (int i = 0; i < 12; i++) begin
            sw_ctrl[0] = ~sw_ctrl[0];
            repeat (DT/3) begin
                @(negedge clk);
                if (io_switches != 4'h2) bounced++;
            end
        end
        check_vec("bounce_no_change", bounced, 0);
        sw_ctrl = 16'h0003;
        found = 1'b0; waited = 0;
        while (!found && waited < 2*DT + 2) begin
            @(negedge clk);
            waited++;
            if (io_switches == 4'h3) found = 1'b1;
        end
        check_vec("bounce_settle", {31'd0, found}, 32'd1);
        check_vec("link_still_up", {31'd0, link_ok}, 32'd1);

        repeat (TOC + 10) @(negedge clk);
        check_vec("to_link_ok", {31'd0, link_ok}, 32'd0);
        check_vec("to_led_addr", {16'd0, led_addr}, 32'd0);
        check_vec("to_led_data", {16'd0, led_data}, 32'd0);
        check_vec("to_serve_kept", {28'd0, io_switches}, 32'h3);

        for (int a = 4; a < 8; a++) host_step(a);
        check_vec("restart_link_ok", {31'd0, link_ok}, 32'd1);
        check_vec("restart_part_addr", {16'd0, led_addr}, 32'h0000);
        check_vec("restart_part_data", {16'd0, led_data}, 32'hBEEF);
        host_frame();
        check_vec("restart_led_addr", {16'd0, led_addr}, 32'h1234);
        check_vec("restart_led_data", {16'd0, led_data}, 32'hBEEF);

`ifdef K16_PANEL_SHADOW_EN
        host_data_w = 16'h0000;
        host_frame();
        check_vec("shadow_zero", {16'd0, led_data}, 32'h0000);
        mon_en = 1'b1;
        host_data_w = 16'hFFFF;
        host_frame();
        mon_en = 1'b0;
        check_vec("shadow_no_tear", torn, 0);
        check_vec("shadow_full", {16'd0, led_data}, 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
